// File: rtl/bullet_scheduler.sv
// Arbitrates tank fire requests onto three shared bullet slots; moves, bounces and retires live bullets each frame.
// Grants and slot outputs appear one cycle after the request; requests that cannot be served are dropped, never queued.
module bullet_scheduler #(
  parameter int XMAX         = 639,
  parameter int YMAX         = 479,
  parameter int LIFE         = 240,
  parameter int MAX_PER_TANK = 2,
  parameter int BSIZE        = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       frame_tick,
  input  logic       clear_all,
  input  logic       fire1_req,
  input  logic       fire2_req,
  input  logic [9:0] Tank1X,
  input  logic [9:0] Tank1Y,
  input  logic [9:0] Tank2X,
  input  logic [9:0] Tank2Y,
  input  logic [3:0] vx1,
  input  logic [3:0] vy1,
  input  logic [3:0] vx2,
  input  logic [3:0] vy2,
  output logic       fire1_ack,
  output logic       fire2_ack,
  output logic [9:0] Bullet1X,
  output logic [9:0] Bullet1Y,
  output logic [9:0] Bullet1S,
  output logic [9:0] Bullet2X,
  output logic [9:0] Bullet2Y,
  output logic [9:0] Bullet2S,
  output logic [9:0] Bullet3X,
  output logic [9:0] Bullet3Y,
  output logic [9:0] Bullet3S,
  output logic       is_bullet1_active,
  output logic       is_bullet2_active,
  output logic       is_bullet3_active,
  output logic       bullet1_owner,
  output logic       bullet2_owner,
  output logic       bullet3_owner
);

  localparam int NS = 3;
  localparam logic signed [10:0] XLIM = 11'(XMAX);
  localparam logic signed [10:0] YLIM = 11'(YMAX);
  localparam logic [1:0] MAXT = 2'(MAX_PER_TANK);
  localparam logic [7:0] LIFE_INIT = 8'(LIFE);

  logic [NS-1:0] r_act;
  logic [NS-1:0] r_own;
  logic [9:0]    r_x    [NS];
  logic [9:0]    r_y    [NS];
  logic [3:0]    r_vx   [NS];
  logic [3:0]    r_vy   [NS];
  logic [7:0]    r_life [NS];
  logic          r_prio;
  logic          r_ack1;
  logic          r_ack2;

  logic [1:0]    w_nfree, w_f0, w_f1, w_cnt1, w_cnt2;
  logic          w_el1, w_el2, w_g1, w_g2, w_flip;
  logic [1:0]    w_idx1, w_idx2;
  logic [NS-1:0] w_gs;
  logic [NS-1:0] w_gown;
  logic [13:0]   w_mx [NS];
  logic [13:0]   w_my [NS];

  function automatic logic [3:0] f_neg(input logic [3:0] v);
    f_neg = (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
  endfunction

  // Returns {velocity, position}; an out-of-range step keeps the position and reflects the velocity.
  function automatic logic [13:0] f_step(input logic [9:0] p, input logic [3:0] v,
                                         input logic signed [10:0] lim);
    logic signed [10:0] n;
    n = $signed({1'b0, p}) + $signed({{7{v[3]}}, v});
    if (n[10] || (n > lim)) f_step = {f_neg(v), p};
    else                    f_step = {v, n[9:0]};
  endfunction

  // A slot expiring this cycle still reads as active, so it cannot be re-granted until next cycle.
  always_comb begin
    w_nfree = '0;
    w_f0    = '0;
    w_f1    = '0;
    w_cnt1  = '0;
    w_cnt2  = '0;
    for (int i = 0; i < NS; i++) begin
      if (r_act[i]) begin
        if (r_own[i]) w_cnt2 = w_cnt2 + 2'd1;
        else          w_cnt1 = w_cnt1 + 2'd1;
      end else begin
        if (w_nfree == 2'd0)      w_f0 = 2'(i);
        else if (w_nfree == 2'd1) w_f1 = 2'(i);
        w_nfree = w_nfree + 2'd1;
      end
    end
  end

  assign w_el1 = fire1_req && (w_cnt1 < MAXT);
  assign w_el2 = fire2_req && (w_cnt2 < MAXT);

  always_comb begin
    w_g1   = 1'b0;
    w_g2   = 1'b0;
    w_idx1 = w_f0;
    w_idx2 = w_f0;
    w_flip = 1'b0;
    if (!clear_all && (w_nfree != 2'd0)) begin
      if (w_el1 && w_el2) begin
        if (w_nfree >= 2'd2) begin
          w_g1   = 1'b1;
          w_g2   = 1'b1;
          w_idx1 = r_prio ? w_f1 : w_f0;
          w_idx2 = r_prio ? w_f0 : w_f1;
        end else begin
          w_g1   = !r_prio;
          w_g2   = r_prio;
          w_flip = 1'b1;
        end
      end else begin
        w_g1 = w_el1;
        w_g2 = w_el2;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      w_gown[i] = w_g2 && (w_idx2 == 2'(i));
      w_gs[i]   = (w_g1 && (w_idx1 == 2'(i))) || w_gown[i];
      w_mx[i]   = f_step(r_x[i], r_vx[i], XLIM);
      w_my[i]   = f_step(r_y[i], r_vy[i], YLIM);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_act  <= '0;
      r_own  <= '0;
      r_prio <= 1'b0;
      r_ack1 <= 1'b0;
      r_ack2 <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        r_x[i]    <= '0;
        r_y[i]    <= '0;
        r_vx[i]   <= '0;
        r_vy[i]   <= '0;
        r_life[i] <= '0;
      end
    end else begin
      r_ack1 <= w_g1;
      r_ack2 <= w_g2;
      if (w_flip) r_prio <= ~r_prio;
      for (int i = 0; i < NS; i++) begin
        if (clear_all) begin
          r_act[i] <= 1'b0;
        end else if (w_gs[i]) begin
          r_act[i]  <= 1'b1;
          r_own[i]  <= w_gown[i];
          r_x[i]    <= w_gown[i] ? Tank2X : Tank1X;
          r_y[i]    <= w_gown[i] ? Tank2Y : Tank1Y;
          r_vx[i]   <= w_gown[i] ? vx2 : vx1;
          r_vy[i]   <= w_gown[i] ? vy2 : vy1;
          r_life[i] <= LIFE_INIT;
        end else if (frame_tick && r_act[i]) begin
          r_life[i] <= r_life[i] - 8'd1;
          if (r_life[i] == 8'd1) begin
            r_act[i] <= 1'b0;
          end else begin
            r_vx[i] <= w_mx[i][13:10];
            r_x[i]  <= w_mx[i][9:0];
            r_vy[i] <= w_my[i][13:10];
            r_y[i]  <= w_my[i][9:0];
          end
        end
      end
    end
  end

  assign fire1_ack         = r_ack1;
  assign fire2_ack         = r_ack2;
  assign Bullet1X          = r_x[0];
  assign Bullet1Y          = r_y[0];
  assign Bullet2X          = r_x[1];
  assign Bullet2Y          = r_y[1];
  assign Bullet3X          = r_x[2];
  assign Bullet3Y          = r_y[2];
  assign Bullet1S          = 10'(BSIZE);
  assign Bullet2S          = 10'(BSIZE);
  assign Bullet3S          = 10'(BSIZE);
  assign is_bullet1_active = r_act[0];
  assign is_bullet2_active = r_act[1];
  assign is_bullet3_active = r_act[2];
  assign bullet1_owner     = r_own[0];
  assign bullet2_owner     = r_own[1];
  assign bullet3_owner     = r_own[2];

endmodule
